// File: rtl/lc3_pkg.sv
// -----------------------------------------------------------------------------
// lc3_pkg
// Shared LC3 definitions: datapath/register-index widths, writeback source
// select encoding, writeback FSM states and the one-hot NZP condition codes.
// -----------------------------------------------------------------------------
package lc3_pkg;

  localparam int DW = 16;  // datapath width
  localparam int RW = 3;   // register-index width (8 registers)

  // Writeback source select as presented by execute.
  typedef enum logic [1:0] {
    WSEL_ALU  = 2'b00,
    WSEL_PC   = 2'b01,
    WSEL_MEM  = 2'b10,
    WSEL_NONE = 2'b11
  } wsel_t;

  typedef enum logic {
    IDLE    = 1'b0,
    MEMWAIT = 1'b1
  } wb_state_t;

  // Condition codes, {N,Z,P}, always exactly one-hot.
  localparam logic [2:0] NZP_N = 3'b100;
  localparam logic [2:0] NZP_Z = 3'b010;
  localparam logic [2:0] NZP_P = 3'b001;

endpackage

// File: rtl/wb_nzp_gen.sv
// -----------------------------------------------------------------------------
// wb_nzp_gen
// Combinational condition-code generator: classifies a DW-bit value as
// negative, zero or positive and returns the one-hot {N,Z,P} code.
// Ports:
//   data  in   DW  value being written to the register file
//   nzp   out  3   one-hot {N,Z,P}
// -----------------------------------------------------------------------------
module wb_nzp_gen #(
  parameter int DW = lc3_pkg::DW
) (
  input  logic [DW-1:0] data,
  output logic [2:0]    nzp
);
  import lc3_pkg::*;

  // Sign bit takes priority, so the result is one-hot by construction.
  always_comb begin
    if (data[DW-1])
      nzp = NZP_N;
    else if (data == '0)
      nzp = NZP_Z;
    else
      nzp = NZP_P;
  end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// LC3 writeback stage. Accepts one retiring instruction per cycle from
// execute, selects the write value (ALU result, PC-derived value or load
// data), drives the register-file write port one cycle later and maintains
// the NZP condition codes. A load whose data has not arrived parks the stage
// in MEMWAIT and stalls execute through exe_ready.
//
// Optional build macro: WB_PERF_CNT_EN adds the retire and memory-wait
// performance counters (wb_retire_cnt, wb_memwait_cnt).
//
// Ports:
//   clk             in   1   clock, all state on rising edge
//   rst             in   1   asynchronous active-low reset
//   exe_valid       in   1   execute presents a retiring instruction
//   exe_ready       out  1   stage accepts this cycle
//   exe_wsel        in   2   write source: 00 ALU, 01 PC, 10 MEM, 11 none
//   exe_dr          in   RW  destination register
//   exe_aluout      in   DW  ALU result
//   exe_pcout       in   DW  PC/LEA value
//   mem_valid       in   1   mem_dout valid this cycle
//   mem_dout        in   DW  load data
//   rf_en           out  1   register-file write enable (one-cycle pulse)
//   rf_dr           out  RW  register-file destination
//   rf_din          out  DW  register-file write data
//   psr_nzp         out  3   condition codes {N,Z,P}
//   wb_busy         out  1   load pending (MEMWAIT)
//   wb_retire_cnt   out  16  accepted instructions   (WB_PERF_CNT_EN only)
//   wb_memwait_cnt  out  16  cycles spent in MEMWAIT (WB_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int DW = lc3_pkg::DW,
  parameter int RW = lc3_pkg::RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          exe_valid,
  output logic          exe_ready,
  input  logic [1:0]    exe_wsel,
  input  logic [RW-1:0] exe_dr,
  input  logic [DW-1:0] exe_aluout,
  input  logic [DW-1:0] exe_pcout,
  input  logic          mem_valid,
  input  logic [DW-1:0] mem_dout,
  output logic          rf_en,
  output logic [RW-1:0] rf_dr,
  output logic [DW-1:0] rf_din,
  output logic [2:0]    psr_nzp,
  output logic          wb_busy
`ifdef WB_PERF_CNT_EN
  ,
  output logic [15:0]   wb_retire_cnt,
  output logic [15:0]   wb_memwait_cnt
`endif
);
  import lc3_pkg::*;

  wb_state_t     state, state_nxt;
  wsel_t         wsel;
  logic          accept;
  logic          load_wait;   // accepted load whose data is not here yet
  logic          wr_en;
  logic [RW-1:0] wr_dr;
  logic [DW-1:0] wr_data;
  logic [2:0]    wr_nzp;
  logic [RW-1:0] ld_dr;       // destination of the load parked in MEMWAIT

  assign wsel   = wsel_t'(exe_wsel);
  assign accept = exe_valid && exe_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: each combinational block assigns defaults first, so no path leaves
  // an output unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (load_wait) state_nxt = MEMWAIT;
      MEMWAIT: if (mem_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / write-select logic
  // ---------------------------------------------------------------------------
  always_comb begin
    exe_ready = 1'b0;
    wb_busy   = 1'b0;
    load_wait = 1'b0;
    wr_en     = 1'b0;
    wr_dr     = exe_dr;
    wr_data   = exe_aluout;
    unique case (state)
      IDLE: begin
        // Reset gates the handshake so nothing is accepted while rst is low.
        exe_ready = rst;
        if (accept) begin
          unique case (wsel)
            WSEL_ALU: begin
              wr_en   = 1'b1;
              wr_data = exe_aluout;
            end
            WSEL_PC: begin
              wr_en   = 1'b1;
              wr_data = exe_pcout;
            end
            WSEL_MEM: begin
              if (mem_valid) begin
                wr_en   = 1'b1;
                wr_data = mem_dout;
              end else begin
                load_wait = 1'b1;
              end
            end
            default: ;  // store/branch: retire without a write
          endcase
        end
      end
      MEMWAIT: begin
        wb_busy = 1'b1;
        if (mem_valid) begin
          wr_en   = 1'b1;
          wr_dr   = ld_dr;
          wr_data = mem_dout;
        end
      end
      default: ;
    endcase
  end

  wb_nzp_gen #(.DW(DW)) u_nzp_gen (
    .data (wr_data),
    .nzp  (wr_nzp)
  );

  // ---------------------------------------------------------------------------
  // Register-file write port, condition codes and parked load destination
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_en   <= 1'b0;
      rf_dr   <= '0;
      rf_din  <= '0;
      psr_nzp <= NZP_Z;
      ld_dr   <= '0;
    end else begin
      // rf_en follows the write decision every cycle, giving a one-cycle pulse.
      rf_en <= wr_en;
      if (wr_en) begin
        rf_dr   <= wr_dr;
        rf_din  <= wr_data;
        psr_nzp <= wr_nzp;
      end
      if (load_wait)
        ld_dr <= exe_dr;
    end
  end

`ifdef WB_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters, free-running and wrapping at 16'hFFFF
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_retire_cnt  <= '0;
      wb_memwait_cnt <= '0;
    end else begin
      if (accept)
        wb_retire_cnt <= wb_retire_cnt + 16'd1;
      if (state == MEMWAIT)
        wb_memwait_cnt <= wb_memwait_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
// Self-checking bench for wb_stage. The driver keeps a behavioural model of
// the stage (busy flag, parked destination, counters) and pushes every
// expected register-file write into a queue; a monitor on the falling edge
// pops and compares whenever rf_en is seen, and otherwise checks that the
// condition codes hold. Build with WB_PERF_CNT_EN to also check the counters.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exe_valid = 1'b0;
  logic        exe_ready;
  logic [1:0]  exe_wsel = 2'b11;
  logic [2:0]  exe_dr = '0;
  logic [15:0] exe_aluout = '0;
  logic [15:0] exe_pcout = '0;
  logic        mem_valid = 1'b0;
  logic [15:0] mem_dout = '0;
  logic        rf_en;
  logic [2:0]  rf_dr;
  logic [15:0] rf_din;
  logic [2:0]  psr_nzp;
  logic        wb_busy;
`ifdef WB_PERF_CNT_EN
  logic [15:0] wb_retire_cnt;
  logic [15:0] wb_memwait_cnt;
`endif

  wb_stage dut (
    .clk        (clk),
    .rst        (rst),
    .exe_valid  (exe_valid),
    .exe_ready  (exe_ready),
    .exe_wsel   (exe_wsel),
    .exe_dr     (exe_dr),
    .exe_aluout (exe_aluout),
    .exe_pcout  (exe_pcout),
    .mem_valid  (mem_valid),
    .mem_dout   (mem_dout),
    .rf_en      (rf_en),
    .rf_dr      (rf_dr),
    .rf_din     (rf_din),
    .psr_nzp    (psr_nzp),
    .wb_busy    (wb_busy)
`ifdef WB_PERF_CNT_EN
    ,
    .wb_retire_cnt  (wb_retire_cnt),
    .wb_memwait_cnt (wb_memwait_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  dr;
    logic [15:0] din;
    logic [2:0]  nzp;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  // Reference model state
  bit          m_busy    = 1'b0;
  logic [2:0]  m_dr      = '0;
  logic [15:0] m_retire  = '0;
  logic [15:0] m_memwait = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Condition codes from the value's meaning: negative, zero or positive.
  function automatic logic [2:0] nzp_of(input logic [15:0] d);
    if ($signed(d) < 0) return 3'b100;
    if (d == 16'd0)     return 3'b010;
    return 3'b001;
  endfunction

  function automatic void push_wr(input logic [2:0] dr, input logic [15:0] d);
    wr_t e;
    e.dr  = dr;
    e.din = d;
    e.nzp = nzp_of(d);
    exp_q.push_back(e);
  endfunction

  function automatic logic [15:0] rnd_data();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'h8000 | 16'($urandom);
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: pops an expected write on each rf_en, otherwise checks NZP hold
  // ---------------------------------------------------------------------------
  logic [2:0] cur_nzp = 3'b010;
  wr_t        mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      cur_nzp = 3'b010;
    end else if (rf_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rf_en", 32'(rf_en), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rf_dr",   32'(rf_dr),   32'(mon_e.dr));
        check("rf_din",  32'(rf_din),  32'(mon_e.din));
        check("psr_nzp", 32'(psr_nzp), 32'(mon_e.nzp));
        cur_nzp = mon_e.nzp;
      end
    end else begin
      check("psr_nzp_hold", 32'(psr_nzp), 32'(cur_nzp));
    end
  end

  // ---------------------------------------------------------------------------
  // One clock of stimulus; advances the model for the coming edge
  // ---------------------------------------------------------------------------
  task automatic step(input bit v, input logic [1:0] ws, input logic [2:0] dr,
                      input logic [15:0] alu, input logic [15:0] pc,
                      input bit mv, input logic [15:0] md, output bit acc);
    @(posedge clk);
    #1;
    exe_valid  = v;
    exe_wsel   = ws;
    exe_dr     = dr;
    exe_aluout = alu;
    exe_pcout  = pc;
    mem_valid  = mv;
    mem_dout   = md;
    #2;
    check("exe_ready", 32'(exe_ready), 32'(!m_busy));
    check("wb_busy",   32'(wb_busy),   32'(m_busy));
    acc = v && !m_busy;
    if (acc) begin
      m_retire++;
      case (ws)
        2'b00: push_wr(dr, alu);
        2'b01: push_wr(dr, pc);
        2'b10: begin
          if (mv) push_wr(dr, md);
          else begin
            m_busy = 1'b1;
            m_dr   = dr;
          end
        end
        default: ;
      endcase
    end else if (m_busy) begin
      m_memwait++;
      if (mv) begin
        push_wr(m_dr, md);
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic idle(input bit mv, input logic [15:0] md);
    bit acc;
    step(1'b0, 2'b11, 3'd0, 16'd0, 16'd0, mv, md, acc);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    exe_valid = 1'b0;
    mem_valid = 1'b0;
    exp_q.delete();
    m_busy    = 1'b0;
    m_retire  = '0;
    m_memwait = '0;
    #2;
    check("exe_ready_in_reset", 32'(exe_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic check_counters();
`ifdef WB_PERF_CNT_EN
    check("wb_retire_cnt",  32'(wb_retire_cnt),  32'(m_retire));
    check("wb_memwait_cnt", 32'(wb_memwait_cnt), 32'(m_memwait));
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit          acc;
    bit          held = 1'b0;
    bit          hv;
    logic [1:0]  hws;
    logic [2:0]  hdr;
    logic [15:0] halu, hpc;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check("reset_rf_en",     32'(rf_en),     32'd0);
    check("reset_rf_dr",     32'(rf_dr),     32'd0);
    check("reset_rf_din",    32'(rf_din),    32'd0);
    check("reset_psr_nzp",   32'(psr_nzp),   32'b010);
    check("reset_exe_ready", 32'(exe_ready), 32'd1);
    check("reset_wb_busy",   32'(wb_busy),   32'd0);
    check_counters();

    // ALU write of a negative value
    step(1'b1, 2'b00, 3'd3, 16'h8001, 16'h1111, 1'b0, 16'h0, acc);
    idle(1'b0, 16'h0);

    // Load waiting three cycles for zero data
    step(1'b1, 2'b10, 3'd5, 16'h1234, 16'h5678, 1'b0, 16'h0, acc);
    idle(1'b0, 16'h0);
    idle(1'b0, 16'h0);
    idle(1'b1, 16'h0000);
    idle(1'b0, 16'h0);

    // Load hit in the same cycle, then mem_valid alone in IDLE (ignored)
    step(1'b1, 2'b10, 3'd2, 16'h0, 16'h0, 1'b1, 16'h7FFF, acc);
    idle(1'b1, 16'h8000);

    // Back-to-back PC write then store/branch
    step(1'b1, 2'b01, 3'd7, 16'hFFFF, 16'h3000, 1'b0, 16'h0, acc);
    step(1'b1, 2'b11, 3'd1, 16'h8000, 16'h0000, 1'b0, 16'h0, acc);
    idle(1'b0, 16'h0);
    idle(1'b0, 16'h0);

    // Reset while a load is pending: load is dropped
    step(1'b1, 2'b10, 3'd3, 16'h0, 16'h0, 1'b0, 16'h0, acc);
    idle(1'b0, 16'h0);
    do_reset();
    idle(1'b1, 16'h8000);
    idle(1'b0, 16'h0);
    check("post_reset_psr_nzp", 32'(psr_nzp), 32'b010);

    // Four accepts including a load that waits two cycles
    do_reset();
    step(1'b1, 2'b00, 3'd1, 16'h0042, 16'h0, 1'b0, 16'h0, acc);
    step(1'b1, 2'b10, 3'd4, 16'h0, 16'h0, 1'b0, 16'h0, acc);
    idle(1'b0, 16'h0);
    idle(1'b1, 16'hA5A5);
    step(1'b1, 2'b01, 3'd6, 16'h0, 16'h0001, 1'b0, 16'h0, acc);
    step(1'b1, 2'b11, 3'd0, 16'h0, 16'h0, 1'b0, 16'h0, acc);
    idle(1'b0, 16'h0);
    check_counters();

    // Randomised traffic; a stalled instruction is held stable by execute
    for (int i = 0; i < 400; i++) begin
      if (!held) begin
        hv   = ($urandom_range(0, 3) != 0);
        hws  = 2'($urandom_range(0, 3));
        hdr  = 3'($urandom_range(0, 7));
        halu = rnd_data();
        hpc  = rnd_data();
      end
      step(hv, hws, hdr, halu, hpc, ($urandom_range(0, 2) == 0), rnd_data(), acc);
      held = hv && !acc;
    end

    // Drain: release any pending load, let the last writes retire
    idle(1'b1, 16'h0001);
    repeat (3) idle(1'b0, 16'h0);
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    check_counters();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
